// File: rtl/mmio_uart_tx.sv
// -----------------------------------------------------------------------------
// mmio_uart_tx
//   Memory-mapped 8N1 UART transmitter with a 4-entry byte FIFO. It sits on the
//   core data port next to dmem. Writing TXDATA queues a byte. STATUS reports
//   the FIFO and FSM state plus a sticky overflow flag, and writing STATUS
//   clears that flag.
//
// Parameters
//   CLKS_PER_BIT  clk cycles per serial bit (2..65535)
//   BASE_ADDR     word-aligned base of the register window
//                 (TXDATA at +0, STATUS at +4)
//
// Ports
//   clk    system clock, rising edge
//   reset  asynchronous, active-high reset
//   we     data-port write strobe
//   a      data-port byte address (a[1:0] ignored)
//   wd     data-port write data (only wd[7:0] used for TXDATA)
//   rdata  combinational read data of the addressed register
//   hit    combinational: a selects one of the two register words
//   tx     registered serial output, idles high
//   busy   FSM not idle or FIFO non-empty
// -----------------------------------------------------------------------------
module mmio_uart_tx #(
  parameter int unsigned CLKS_PER_BIT = 16,
  parameter logic [31:0] BASE_ADDR    = 32'h0000_0100
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        we,
  input  logic [31:0] a,
  input  logic [31:0] wd,
  output logic [31:0] rdata,
  output logic        hit,
  output logic        tx,
  output logic        busy
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP
  } state_t;

  localparam logic [15:0] BAUD_LAST   = 16'(CLKS_PER_BIT - 1);
  localparam logic [29:0] TXDATA_WORD = BASE_ADDR[31:2];
  localparam logic [29:0] STATUS_WORD = BASE_ADDR[31:2] + 30'd1;

  state_t      r_state;
  logic [15:0] r_baud;
  logic [2:0]  r_idx;
  logic [7:0]  r_shift;
  logic        r_tx;

  logic [7:0]  r_mem [4];
  logic [1:0]  r_wr_ptr;
  logic [1:0]  r_rd_ptr;
  logic [2:0]  r_count;
  logic        r_overflow;

  logic        w_sel_data;
  logic        w_sel_status;
  logic        w_full;
  logic        w_empty;
  logic        w_active;
  logic        w_baud_last;
  logic        w_push;
  logic        w_push_ok;
  logic        w_pop;
  logic [2:0]  w_idx_next;
  logic        w_unused;

  // Address decode on the word address only.
  assign w_sel_data   = (a[31:2] == TXDATA_WORD);
  assign w_sel_status = (a[31:2] == STATUS_WORD);
  assign hit          = w_sel_data | w_sel_status;

  assign w_full      = (r_count == 3'd4);
  assign w_empty     = (r_count == 3'd0);
  assign w_active    = (r_state != S_IDLE);
  assign w_baud_last = (r_baud == BAUD_LAST);
  assign w_idx_next  = r_idx + 3'd1;

  // A pop happens when a new frame is launched: from IDLE, or on the last
  // cycle of STOP so back-to-back frames have no gap.
  assign w_pop = !w_empty &&
                 ((r_state == S_IDLE) || ((r_state == S_STOP) && w_baud_last));

  // A push into a full FIFO is only accepted if a pop frees the slot at the
  // same edge; otherwise it is dropped and flagged as overflow.
  assign w_push    = we && w_sel_data;
  assign w_push_ok = w_push && (!w_full || w_pop);

  assign busy = w_active || !w_empty;
  assign tx   = r_tx;

  assign w_unused = ^{wd[31:8], a[1:0]};

  // NOTE: combinational blocks assign a default first so no path leaves the
  // output unassigned, which would infer a latch.
  always_comb begin
    rdata = 32'h0;
    if (w_sel_status) begin
      rdata = {25'b0, r_count, r_overflow, w_active, w_empty, w_full};
    end
  end

  // FIFO storage. NOTE: the data array has no reset; contents are only ever
  // read behind a non-zero count, so clearing them would buy nothing.
  always_ff @(posedge clk) begin
    if (w_push_ok) begin
      r_mem[r_wr_ptr] <= wd[7:0];
    end
  end

  // FIFO pointers, count and sticky overflow.
  // NOTE: sequential state is updated with non-blocking assignments so every
  // flop samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wr_ptr   <= 2'd0;
      r_rd_ptr   <= 2'd0;
      r_count    <= 3'd0;
      r_overflow <= 1'b0;
    end else begin
      if (w_push_ok) r_wr_ptr <= r_wr_ptr + 2'd1;
      if (w_pop)     r_rd_ptr <= r_rd_ptr + 2'd1;
      case ({w_push_ok, w_pop})
        2'b10:   r_count <= r_count + 3'd1;
        2'b01:   r_count <= r_count - 3'd1;
        default: r_count <= r_count;
      endcase
      if (we && w_sel_status) begin
        r_overflow <= 1'b0;
      end else if (w_push && w_full && !w_pop) begin
        r_overflow <= 1'b1;
      end
    end
  end

  // Transmit FSM. tx is loaded with the level of the bit being entered, so
  // the line changes on the same edge as the state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_baud  <= 16'd0;
      r_idx   <= 3'd0;
      r_shift <= 8'h00;
      r_tx    <= 1'b1;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_tx <= 1'b1;
          if (w_pop) begin
            r_shift <= r_mem[r_rd_ptr];
            r_baud  <= 16'd0;
            r_state <= S_START;
            r_tx    <= 1'b0;
          end
        end
        S_START: begin
          if (w_baud_last) begin
            r_baud  <= 16'd0;
            r_idx   <= 3'd0;
            r_state <= S_DATA;
            r_tx    <= r_shift[0];
          end else begin
            r_baud <= r_baud + 16'd1;
          end
        end
        S_DATA: begin
          if (w_baud_last) begin
            r_baud <= 16'd0;
            if (r_idx == 3'd7) begin
              r_state <= S_STOP;
              r_tx    <= 1'b1;
            end else begin
              r_idx <= w_idx_next;
              r_tx  <= r_shift[w_idx_next];
            end
          end else begin
            r_baud <= r_baud + 16'd1;
          end
        end
        S_STOP: begin
          if (w_baud_last) begin
            r_baud <= 16'd0;
            if (w_pop) begin
              r_shift <= r_mem[r_rd_ptr];
              r_state <= S_START;
              r_tx    <= 1'b0;
            end else begin
              r_state <= S_IDLE;
              r_tx    <= 1'b1;
            end
          end else begin
            r_baud <= r_baud + 16'd1;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_tx    <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mmio_uart_tx.sv
// -----------------------------------------------------------------------------
// tb_mmio_uart_tx
//   Directed bench for mmio_uart_tx with CLKS_PER_BIT=4 (40-cycle frames).
//   Cycle e is the interval after rising edge e of a script; scripted writes
//   are applied at edge e, and tx/busy/STATUS are logged 1-2 time units after
//   each edge. Expected tx levels come from a frame model built from the list
//   of bytes that should be sent, starting at cycle 1.
// -----------------------------------------------------------------------------
module tb_mmio_uart_tx;

  localparam int CPB   = 4;
  localparam int FRAME = 10 * CPB;

  logic        clk = 1'b0;
  logic        reset;
  logic        we;
  logic [31:0] a;
  logic [31:0] wd;
  logic [31:0] rdata;
  logic        hit;
  logic        tx;
  logic        busy;

  int checks   = 0;
  int failures = 0;

  // Write schedule and expected bytes for run_script.
  int          sched_e[$];
  logic [31:0] sched_a[$];
  logic [31:0] sched_d[$];
  logic [7:0]  exp_bytes[$];

  logic        tx_log   [0:511];
  logic        busy_log [0:511];
  logic [31:0] stat_log [0:511];

  mmio_uart_tx #(
    .CLKS_PER_BIT(CPB),
    .BASE_ADDR   (32'h0000_0100)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .we   (we),
    .a    (a),
    .wd   (wd),
    .rdata(rdata),
    .hit  (hit),
    .tx   (tx),
    .busy (busy)
  );

  always #5 clk = ~clk;

  // Expected line level in cycle e when exp_bytes are sent back to back with
  // the first start bit in cycle 1.
  function automatic logic exp_tx(input int e);
    int f;
    int k;
    logic [7:0] b;
    if (e < 1) return 1'b1;
    f = (e - 1) / FRAME;
    k = (e - 1) % FRAME;
    if (f >= exp_bytes.size()) return 1'b1;
    b = exp_bytes[f];
    if (k < CPB) return 1'b0;
    if (k < 9 * CPB) return b[(k - CPB) / CPB];
    return 1'b1;
  endfunction

  task automatic clear_script();
    sched_e.delete();
    sched_a.delete();
    sched_d.delete();
    exp_bytes.delete();
  endtask

  task automatic add_write(input int e, input logic [31:0] addr, input logic [31:0] data);
    sched_e.push_back(e);
    sched_a.push_back(addr);
    sched_d.push_back(data);
  endtask

  // Runs edges 0..n from a point just after a rising edge, logging outputs.
  task automatic run_script(input int n);
    for (int e = 0; e <= n; e++) begin
      we = 1'b0;
      a  = 32'h0;
      wd = 32'h0;
      for (int i = 0; i < sched_e.size(); i++) begin
        if (sched_e[i] == e) begin
          we = 1'b1;
          a  = sched_a[i];
          wd = sched_d[i];
        end
      end
      @(posedge clk);
      #1;
      we          = 1'b0;
      tx_log[e]   = tx;
      busy_log[e] = busy;
      a           = 32'h104;
      #1;
      stat_log[e] = rdata;
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    we    = 1'b0;
    a     = 32'h104;
    wd    = 32'h0;
    #1 reset = 1'b1;
    #1;
    checks++;
    if (tx !== 1'b1) begin failures++; $display("FAIL reset_tx got=%b want=1", tx); end
    checks++;
    if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b want=0", busy); end
    checks++;
    if (rdata !== 32'h2 || hit !== 1'b1) begin
      failures++; $display("FAIL reset_status got=%h/%b want=00000002/1", rdata, hit);
    end
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    #1;
    checks++;
    if (rdata !== 32'h2) begin failures++; $display("FAIL post_reset_status got=%h want=00000002", rdata); end
  endtask

  task automatic test_read_map();
    logic [31:0] addrs [5] = '{32'h104, 32'h108, 32'h100, 32'h107, 32'h0FC};
    logic [31:0] exp_d [5] = '{32'h2, 32'h0, 32'h0, 32'h2, 32'h0};
    logic        exp_h [5] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    for (int i = 0; i < 5; i++) begin
      a = addrs[i];
      #1;
      checks++;
      if (rdata !== exp_d[i] || hit !== exp_h[i]) begin
        failures++;
        $display("FAIL read_map addr=%h got=%h/%b want=%h/%b", addrs[i], rdata, hit, exp_d[i], exp_h[i]);
      end
    end
  endtask

  task automatic check_tx_range(input string name, input int n);
    for (int e = 0; e <= n; e++) begin
      checks++;
      if (tx_log[e] !== exp_tx(e)) begin
        failures++;
        $display("FAIL %s tx cycle=%0d got=%b want=%b", name, e, tx_log[e], exp_tx(e));
      end
    end
  endtask

  task automatic test_single_frame();
    clear_script();
    add_write(0, 32'h100, 32'h0000_00A5);
    exp_bytes = '{8'hA5};
    run_script(42);
    check_tx_range("single_a5", 42);
    checks++;
    if (busy_log[40] !== 1'b1) begin failures++; $display("FAIL single_busy40 got=%b want=1", busy_log[40]); end
    checks++;
    if (busy_log[41] !== 1'b0) begin failures++; $display("FAIL single_busy41 got=%b want=0", busy_log[41]); end

    // Upper data bits and a[1:0] are ignored on the push.
    clear_script();
    add_write(0, 32'h102, 32'hDEAD_BE3C);
    exp_bytes = '{8'h3C};
    run_script(42);
    check_tx_range("single_3c", 42);
    checks++;
    if (stat_log[0] !== 32'h10) begin failures++; $display("FAIL status_after_push got=%h want=00000010", stat_log[0]); end
    checks++;
    if (stat_log[1] !== 32'h06) begin failures++; $display("FAIL status_after_pop got=%h want=00000006", stat_log[1]); end
  endtask

  task automatic test_back_to_back();
    clear_script();
    for (int i = 0; i < 5; i++) add_write(i, 32'h100, 32'h11 + i);
    exp_bytes = '{8'h11, 8'h12, 8'h13, 8'h14, 8'h15};
    run_script(202);
    check_tx_range("burst", 202);
    checks++;
    if (stat_log[4] !== 32'h45) begin failures++; $display("FAIL burst_status4 got=%h want=00000045", stat_log[4]); end
    checks++;
    if (busy_log[200] !== 1'b1 || busy_log[201] !== 1'b0) begin
      failures++; $display("FAIL burst_busy_end got=%b%b want=10", busy_log[200], busy_log[201]);
    end
    checks++;
    if (stat_log[201] !== 32'h02) begin failures++; $display("FAIL burst_status_end got=%h want=00000002", stat_log[201]); end
  endtask

  task automatic test_overflow();
    clear_script();
    add_write(0, 32'h100, 32'h01);
    for (int i = 0; i < 4; i++) add_write(2 + i, 32'h100, 32'h21 + i);
    add_write(6, 32'h100, 32'h25);   // dropped
    add_write(7, 32'h104, 32'h0);    // clears overflow
    exp_bytes = '{8'h01, 8'h21, 8'h22, 8'h23, 8'h24};
    run_script(205);
    check_tx_range("overflow", 205);
    // A frame is in flight, so the tx-active bit is set alongside full.
    checks++;
    if (stat_log[5] !== 32'h45) begin failures++; $display("FAIL ovf_status_full got=%h want=00000045", stat_log[5]); end
    checks++;
    if (stat_log[6] !== 32'h4D) begin failures++; $display("FAIL ovf_status_set got=%h want=0000004d", stat_log[6]); end
    checks++;
    if (stat_log[7] !== 32'h45) begin failures++; $display("FAIL ovf_status_clr got=%h want=00000045", stat_log[7]); end
    checks++;
    if (busy_log[201] !== 1'b0) begin failures++; $display("FAIL ovf_busy_end got=%b want=0", busy_log[201]); end
  endtask

  task automatic test_stop_collision();
    clear_script();
    add_write(0, 32'h100, 32'h30);
    for (int i = 0; i < 4; i++) add_write(2 + i, 32'h100, 32'h31 + i);
    add_write(41, 32'h100, 32'h35);  // same edge as the STOP-end pop
    exp_bytes = '{8'h30, 8'h31, 8'h32, 8'h33, 8'h34, 8'h35};
    run_script(245);
    check_tx_range("collision", 245);
    checks++;
    if (stat_log[40] !== 32'h45) begin failures++; $display("FAIL coll_status40 got=%h want=00000045", stat_log[40]); end
    checks++;
    if (stat_log[41] !== 32'h45) begin failures++; $display("FAIL coll_status41 got=%h want=00000045", stat_log[41]); end
    checks++;
    if (busy_log[240] !== 1'b1 || busy_log[241] !== 1'b0) begin
      failures++; $display("FAIL coll_busy_end got=%b%b want=10", busy_log[240], busy_log[241]);
    end
    checks++;
    if (stat_log[241] !== 32'h02) begin failures++; $display("FAIL coll_status_end got=%h want=00000002", stat_log[241]); end
  endtask

  task automatic test_reset_midframe();
    clear_script();
    add_write(0, 32'h100, 32'h55);
    add_write(1, 32'h100, 32'h56);
    add_write(2, 32'h100, 32'h57);
    run_script(10);
    // Cycle 10 carries data bit 1 of 0x55, which is 0.
    checks++;
    if (tx !== 1'b0) begin failures++; $display("FAIL midframe_pre_tx got=%b want=0", tx); end
    reset = 1'b1;
    #1;
    checks++;
    if (tx !== 1'b1) begin failures++; $display("FAIL midframe_async_tx got=%b want=1", tx); end
    checks++;
    if (busy !== 1'b0) begin failures++; $display("FAIL midframe_async_busy got=%b want=0", busy); end
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    a = 32'h104;
    #1;
    checks++;
    if (rdata !== 32'h2 || busy !== 1'b0) begin
      failures++; $display("FAIL midframe_release got=%h/%b want=00000002/0", rdata, busy);
    end
    clear_script();
    run_script(50);
    for (int e = 0; e <= 50; e++) begin
      checks++;
      if (tx_log[e] !== 1'b1 || busy_log[e] !== 1'b0) begin
        failures++; $display("FAIL midframe_quiet cycle=%0d got=%b/%b want=1/0", e, tx_log[e], busy_log[e]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_read_map();
    test_single_frame();
    test_back_to_back();
    test_overflow();
    test_stop_collision();
    test_reset_midframe();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
